// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parametrised register file.
//   rf_state_t : clear-sweep / run state of the top-level sequencer
//   Def*       : default parameter values used by regfile_param
//   rf_addr_w  : address width needed to index n registers
package regfile_pkg;

  typedef enum logic [0:0] {
    StClear,
    StRun
  } rf_state_t;

  localparam int unsigned DefDataW   = 64;
  localparam int unsigned DefNumRegs = 32;
  localparam int unsigned DefZeroIdx = 31;
  localparam int unsigned DefSpIdx   = 21;
  localparam logic [63:0] DefSpInit  = 64'h1000;

  function automatic int unsigned rf_addr_w(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register.
//   clr_all_i            : clears every bit (highest priority)
//   set_i / set_addr_i   : marks a register pending (wins over a same-cycle clear)
//   clr_i / clr_addr_i   : retires a pending write
//   q_addr_*_i/pend_*_o  : two query ports; out-of-range addresses read 0
// Strobes arrive pre-qualified (busy, zero register and range already filtered).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = DefNumRegs,
  parameter int unsigned ADDR_W   = rf_addr_w(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_all_i,
  input  logic              set_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] q_addr_a_i,
  input  logic [ADDR_W-1:0] q_addr_b_i,
  output logic              pend_a_o,
  output logic              pend_b_o
);

  logic [NUM_REGS-1:0] pend_q, pend_d;

  always_comb begin
    pend_d = pend_q;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (clr_i && clr_addr_i == ADDR_W'(i)) pend_d[i] = 1'b0;
      if (set_i && set_addr_i == ADDR_W'(i)) pend_d[i] = 1'b1;
    end
    if (clr_all_i) pend_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend_a_o = (32'(q_addr_a_i) < NUM_REGS) ? pend_q[q_addr_a_i] : 1'b0;
  assign pend_b_o = (32'(q_addr_b_i) < NUM_REGS) ? pend_q[q_addr_b_i] : 1'b0;

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: 2 async read ports, 1 sync write port, pending-write
// scoreboard and a clear sequencer that sweeps every register after reset or clr_req_i.
//   rd_addr_*_i / rd_data_*_o : combinational reads (0 for zero reg, out of range, busy)
//   pend_*_o                  : outstanding-write flag for the read addresses
//   wr_en_i/wr_addr_i/wr_data_i : writeback port
//   sb_set_i/sb_addr_i        : issue-time scoreboard set
//   clr_req_i                 : start a full clear sweep (ignored while sweeping)
//   busy_o                    : sweep in progress, pipeline must stall
// Optional: define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int unsigned           DATA_W   = DefDataW,
  parameter int unsigned           NUM_REGS = DefNumRegs,
  parameter int unsigned           ZERO_IDX = DefZeroIdx,
  parameter int unsigned           SP_IDX   = DefSpIdx,
  parameter logic [DATA_W-1:0]     SP_INIT  = DATA_W'(DefSpInit),
  localparam int unsigned          ADDR_W   = rf_addr_w(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] rd_addr_a_i,
  input  logic [ADDR_W-1:0] rd_addr_b_i,
  output logic [DATA_W-1:0] rd_data_a_o,
  output logic [DATA_W-1:0] rd_data_b_o,
  output logic              pend_a_o,
  output logic              pend_b_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              sb_set_i,
  input  logic [ADDR_W-1:0] sb_addr_i,
  input  logic              clr_req_i,
  output logic              busy_o
);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic              busy, wr_valid, set_valid, clr_all;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata;
  logic              sb_pend_a, sb_pend_b;
  logic              hit_a, hit_b, fwd_clr_a, fwd_clr_b;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
    return (32'(addr) < NUM_REGS) && (addr != ADDR_W'(ZERO_IDX));
  endfunction

  assign busy      = (state_q == StClear);
  assign busy_o    = busy;
  assign wr_valid  = wr_en_i & ~busy & addr_ok(wr_addr_i);
  assign set_valid = sb_set_i & ~busy & addr_ok(sb_addr_i);
  assign clr_all   = clr_req_i & ~busy;

  // Sweep sequencer
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StClear: begin
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d = StRun;
          idx_d   = '0;
        end
      end
      StRun: begin
        if (clr_req_i) begin
          state_d = StClear;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = StClear;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StClear;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Single array write port shared by the sweep and writeback
  always_comb begin
    arr_we    = busy | wr_valid;
    arr_waddr = busy ? idx_q : wr_addr_i;
    arr_wdata = wr_data_i;
    if (busy) arr_wdata = (idx_q == ADDR_W'(SP_IDX)) ? SP_INIT : '0;
  end

  // Contents deliberately not reset; the sweep initialises them.
  always_ff @(posedge clk_i) begin
    if (arr_we) regs_q[arr_waddr] <= arr_wdata;
  end

`ifdef REGFILE_BYPASS_EN
  assign hit_a     = wr_valid && (wr_addr_i == rd_addr_a_i);
  assign hit_b     = wr_valid && (wr_addr_i == rd_addr_b_i);
  // A retiring write hides the pending bit unless the same register is re-issued now
  assign fwd_clr_a = hit_a && !(set_valid && (sb_addr_i == rd_addr_a_i));
  assign fwd_clr_b = hit_b && !(set_valid && (sb_addr_i == rd_addr_b_i));
`else
  assign hit_a     = 1'b0;
  assign hit_b     = 1'b0;
  assign fwd_clr_a = 1'b0;
  assign fwd_clr_b = 1'b0;
`endif

  always_comb begin
    rd_data_a_o = '0;
    rd_data_b_o = '0;
    if (!busy && addr_ok(rd_addr_a_i)) rd_data_a_o = hit_a ? wr_data_i : regs_q[rd_addr_a_i];
    if (!busy && addr_ok(rd_addr_b_i)) rd_data_b_o = hit_b ? wr_data_i : regs_q[rd_addr_b_i];
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_all_i  (clr_all),
    .set_i      (set_valid),
    .set_addr_i (sb_addr_i),
    .clr_i      (wr_valid),
    .clr_addr_i (wr_addr_i),
    .q_addr_a_i (rd_addr_a_i),
    .q_addr_b_i (rd_addr_b_i),
    .pend_a_o   (sb_pend_a),
    .pend_b_o   (sb_pend_b)
  );

  assign pend_a_o = sb_pend_a & ~busy & ~fwd_clr_a;
  assign pend_b_o = sb_pend_b & ~busy & ~fwd_clr_b;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param (default parameters: 64 x 32, zero r31, SP r21).
// Reference model: plain arrays for contents and pending bits, plus a sweep countdown.
module tb_regfile_param;

  localparam int NR  = 32;
  localparam int ZI  = 31;
  localparam int SPI = 21;

  logic        clk, rst_n;
  logic [4:0]  rd_addr_a, rd_addr_b, wr_addr, sb_addr;
  logic [63:0] rd_data_a, rd_data_b, wr_data;
  logic        pend_a, pend_b, wr_en, sb_set, clr_req, busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] m_regs [NR];
  bit          m_pend [NR];
  int          sweep_left;

  regfile_param dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rd_addr_a_i (rd_addr_a),
    .rd_addr_b_i (rd_addr_b),
    .rd_data_a_o (rd_data_a),
    .rd_data_b_o (rd_data_b),
    .pend_a_o    (pend_a),
    .pend_b_o    (pend_b),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .sb_set_i    (sb_set),
    .sb_addr_i   (sb_addr),
    .clr_req_i   (clr_req),
    .busy_o      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] exp_rd(input logic [4:0] addr);
    if (sweep_left > 0 || int'(addr) == ZI) return 64'h0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && int'(wr_addr) != ZI && wr_addr == addr) return wr_data;
`endif
    return m_regs[addr];
  endfunction

  function automatic logic exp_pend(input logic [4:0] addr);
    if (sweep_left > 0 || int'(addr) == ZI) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && int'(wr_addr) != ZI && wr_addr == addr &&
        !(sb_set && int'(sb_addr) != ZI && sb_addr == addr)) return 1'b0;
`endif
    return m_pend[addr];
  endfunction

  // Advance one clock; the model applies the architectural effect of the current inputs.
  task automatic tick();
    bit wv, sv;
    if (sweep_left > 0) begin
      sweep_left--;
      if (sweep_left == 0)
        for (int i = 0; i < NR; i++) m_regs[i] = (i == SPI) ? 64'h1000 : 64'h0;
    end else begin
      wv = wr_en && int'(wr_addr) != ZI;
      sv = sb_set && int'(sb_addr) != ZI;
      if (wv) m_regs[wr_addr] = wr_data;
      if (clr_req) begin
        for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
        sweep_left = NR;
      end else begin
        if (wv) m_pend[wr_addr] = 1'b0;
        if (sv) m_pend[sb_addr] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; sb_set = 1'b0; clr_req = 1'b0;
    wr_addr = '0; wr_data = '0; sb_addr = '0;
  endtask

  task automatic test_reset();
    int cnt;
    idle_inputs();
    rd_addr_a = 5'd21; rd_addr_b = 5'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", busy); end
    n_tests++;
    if (rd_data_a !== 64'h0) begin
      n_fail++; $display("FAIL reset_rd_a: got %h expected 0", rd_data_a);
    end
    n_tests++;
    if (pend_a !== 1'b0) begin n_fail++; $display("FAIL reset_pend_a: got %b expected 0", pend_a); end
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
    sweep_left = NR;
    cnt = 0;
    while (busy && cnt < 100) begin tick(); cnt++; end
    n_tests++;
    if (cnt !== NR) begin n_fail++; $display("FAIL reset_busy_len: got %0d expected %0d", cnt, NR); end
    for (int i = 0; i < NR; i++) begin
      rd_addr_a = 5'(i); rd_addr_b = 5'(NR - 1 - i);
      #1;
      n_tests++;
      if (rd_data_a !== ((i == SPI) ? 64'h1000 : 64'h0)) begin
        n_fail++; $display("FAIL reset_init_r%0d: got %h expected %h", i, rd_data_a, exp_rd(rd_addr_a));
      end
      n_tests++;
      if (rd_data_b !== exp_rd(rd_addr_b)) begin
        n_fail++; $display("FAIL reset_init_b_r%0d: got %h expected %h", NR - 1 - i, rd_data_b,
                           exp_rd(rd_addr_b));
      end
    end
  endtask

  task automatic test_write();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEADBEEF;
    tick();
    wr_addr = 5'd31; wr_data = 64'h55;
    tick();
    idle_inputs();
    rd_addr_a = 5'd5; rd_addr_b = 5'd31;
    #1;
    n_tests++;
    if (rd_data_a !== 64'hDEADBEEF) begin
      n_fail++; $display("FAIL write_r5: got %h expected deadbeef", rd_data_a);
    end
    n_tests++;
    if (rd_data_b !== 64'h0) begin n_fail++; $display("FAIL write_r31: got %h expected 0", rd_data_b); end
  endtask

  task automatic test_bypass();
    logic [63:0] exp;
    rd_addr_a = 5'd5;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h1234;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp = 64'h1234;
`else
    exp = 64'hDEADBEEF;
`endif
    n_tests++;
    if (rd_data_a !== exp) begin
      n_fail++; $display("FAIL bypass_same_cycle: got %h expected %h", rd_data_a, exp);
    end
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if (rd_data_a !== 64'h1234) begin
      n_fail++; $display("FAIL bypass_next_cycle: got %h expected 1234", rd_data_a);
    end
  endtask

  task automatic test_scoreboard();
    logic exp;
    rd_addr_a = 5'd7; rd_addr_b = 5'd31;
    sb_set = 1'b1; sb_addr = 5'd7;
    #1;
    n_tests++;
    if (pend_a !== 1'b0) begin n_fail++; $display("FAIL sb_before_set: got %b expected 0", pend_a); end
    tick();
    sb_set = 1'b0;
    #1;
    n_tests++;
    if (pend_a !== 1'b1) begin n_fail++; $display("FAIL sb_set: got %b expected 1", pend_a); end
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h77; sb_set = 1'b1; sb_addr = 5'd7;
    tick();
    sb_set = 1'b0;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp = 1'b0;
`else
    exp = 1'b1;
`endif
    n_tests++;
    if (pend_a !== exp) begin
      n_fail++; $display("FAIL sb_write_alone_comb: got %b expected %b", pend_a, exp);
    end
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if (pend_a !== 1'b0) begin n_fail++; $display("FAIL sb_set_wins_then_clear: got %b expected 0", pend_a); end
    sb_set = 1'b1; sb_addr = 5'd31;
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if (pend_b !== 1'b0) begin n_fail++; $display("FAIL sb_zero_reg: got %b expected 0", pend_b); end
  endtask

  task automatic test_clear();
    int cnt;
    sb_set = 1'b1; sb_addr = 5'd3;
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = {$urandom, $urandom};
    tick();
    idle_inputs();
    rd_addr_a = 5'd3;
    #1;
    n_tests++;
    if (pend_a !== 1'b1) begin n_fail++; $display("FAIL clr_pre_pend: got %b expected 1", pend_a); end
    clr_req = 1'b1;
    tick();
    cnt = 0;
    // Hold writes, issues and further clear requests for the whole sweep; all must be ignored
    while (busy && cnt < 100) begin
      wr_en = 1'b1; wr_addr = 5'($urandom_range(0, 30)); wr_data = {$urandom, $urandom};
      sb_set = 1'b1; sb_addr = 5'($urandom_range(0, 30));
      if (cnt == 5) begin
        rd_addr_a = wr_addr;
        #1;
        n_tests++;
        if (rd_data_a !== 64'h0 || pend_a !== 1'b0) begin
          n_fail++; $display("FAIL clr_busy_read: got %h/%b expected 0/0", rd_data_a, pend_a);
        end
      end
      tick();
      cnt++;
    end
    idle_inputs();
    n_tests++;
    if (cnt !== NR) begin n_fail++; $display("FAIL clr_busy_len: got %0d expected %0d", cnt, NR); end
    for (int i = 0; i < NR; i++) begin
      rd_addr_a = 5'(i); rd_addr_b = 5'(i);
      #1;
      n_tests++;
      if (rd_data_a !== exp_rd(rd_addr_a) || pend_b !== 1'b0) begin
        n_fail++; $display("FAIL clr_state_r%0d: got %h/%b expected %h/0", i, rd_data_a, pend_b,
                           exp_rd(rd_addr_a));
      end
    end
    rd_addr_a = 5'd21;
    #1;
    n_tests++;
    if (rd_data_a !== 64'h1000) begin n_fail++; $display("FAIL clr_sp: got %h expected 1000", rd_data_a); end
  endtask

  task automatic test_reset_mid_sweep();
    int cnt;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy: got %b expected 1", busy); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
    sweep_left = NR;
    cnt = 0;
    while (busy && cnt < 100) begin tick(); cnt++; end
    n_tests++;
    if (cnt !== NR) begin n_fail++; $display("FAIL midrst_busy_len: got %0d expected %0d", cnt, NR); end
    rd_addr_a = 5'd21;
    #1;
    n_tests++;
    if (rd_data_a !== 64'h1000) begin n_fail++; $display("FAIL midrst_sp: got %h expected 1000", rd_data_a); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      wr_en   = ($urandom_range(0, 1) == 1);
      wr_addr = 5'($urandom_range(0, NR - 1));
      wr_data = {$urandom, $urandom};
      sb_set  = ($urandom_range(0, 2) == 0);
      sb_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, NR - 1));
      rd_addr_a = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom_range(0, NR - 1));
      rd_addr_b = ($urandom_range(0, 2) == 0) ? sb_addr : 5'($urandom_range(0, NR - 1));
      #1;
      n_tests++;
      if (rd_data_a !== exp_rd(rd_addr_a) || rd_data_b !== exp_rd(rd_addr_b)) begin
        n_fail++; $display("FAIL rand_rd[%0d]: got a=%h b=%h expected a=%h b=%h", n, rd_data_a,
                           rd_data_b, exp_rd(rd_addr_a), exp_rd(rd_addr_b));
      end
      n_tests++;
      if (pend_a !== exp_pend(rd_addr_a) || pend_b !== exp_pend(rd_addr_b)) begin
        n_fail++; $display("FAIL rand_pend[%0d]: got a=%b b=%b expected a=%b b=%b", n, pend_a,
                           pend_b, exp_pend(rd_addr_a), exp_pend(rd_addr_b));
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    sweep_left = 0;
    for (int i = 0; i < NR; i++) begin m_regs[i] = '0; m_pend[i] = 1'b0; end
    rd_addr_a = '0; rd_addr_b = '0;
    test_reset();
    test_write();
    test_bypass();
    test_scoreboard();
    test_clear();
    test_random();
    test_reset_mid_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
